// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO frequency-sweep controller.
package nco_pkg;

    typedef enum logic [1:0] {StIdle, StRamp, StHold} sweep_state_e;

    localparam int unsigned LutsizeDefault = 10;
    localparam int unsigned FracWDefault   = 8;
    localparam int unsigned DwellWDefault  = 16;

    function automatic int unsigned ftw_width(input int unsigned lutsize,
                                              input int unsigned frac_w);
        return lutsize + 1 + frac_w;
    endfunction

endpackage

// File: rtl/nco_dwell_timer.sv
// Enable-gated dwell counter; expire_o is high on the enabled cycle that completes a dwell.
module nco_dwell_timer #(
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               expire_o
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W:0]   target;
    logic [DWELL_W:0]   cnt_inc;

    always_comb begin
        // A dwell of zero behaves as a single-cycle dwell.
        target   = (dwell_i == '0) ? {{DWELL_W{1'b0}}, 1'b1} : {1'b0, dwell_i};
        cnt_inc  = {1'b0, cnt_q} + {{DWELL_W{1'b0}}, 1'b1};
        expire_o = en_i && !clr_i && (cnt_inc >= target);
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_inc[DWELL_W-1:0];
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nco_sweep.sv
// Frequency-sweep controller driving the NCO integer/fractional tuning word.
module nco_sweep
    import nco_pkg::*;
#(
    parameter int unsigned LUTSIZE = LutsizeDefault,
    parameter int unsigned FRAC_W  = FracWDefault,
    parameter int unsigned DWELL_W = DwellWDefault,
    localparam int unsigned FTW_W  = ftw_width(LUTSIZE, FRAC_W)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [FTW_W-1:0]   start_ftw_i,
    input  logic [FTW_W-1:0]   stop_ftw_i,
    input  logic [FTW_W-1:0]   step_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic               repeat_i,
    input  logic               tri_i,
    output logic [LUTSIZE:0]   iftw_o,
    output logic [FRAC_W-1:0]  fftw_o,
    output logic               busy_o,
    output logic               step_tick_o,
    output logic               done_o
);

    sweep_state_e       state_q, state_d;
    logic [FTW_W-1:0]   ftw_q, ftw_d, start_q, start_d, stop_q, stop_d, step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               dir_up_q, dir_up_d, repeat_q, repeat_d, tri_q, tri_d;
    logic               step_tick_q, step_tick_d, done_q, done_d;
    logic               expire, timer_clr, hit;
    logic [FTW_W:0]     sum, diff;

    assign timer_clr = (state_q == StIdle) || start_i || abort_i;

    nco_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (en_i),
        .clr_i    (timer_clr),
        .dwell_i  (dwell_q),
        .expire_o (expire)
    );

    // One extra bit catches wrap past either end of the tuning range.
    always_comb begin
        sum  = {1'b0, ftw_q} + {1'b0, step_q};
        diff = {1'b0, ftw_q} - {1'b0, step_q};
        if (dir_up_q) begin
            hit = sum[FTW_W] || (sum[FTW_W-1:0] >= stop_q) || (step_q == '0);
        end else begin
            hit = diff[FTW_W] || (diff[FTW_W-1:0] <= stop_q) || (step_q == '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            ftw_q       <= '0;
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            dir_up_q    <= 1'b0;
            repeat_q    <= 1'b0;
            tri_q       <= 1'b0;
            step_tick_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ftw_q       <= ftw_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            step_q      <= step_d;
            dwell_q     <= dwell_d;
            dir_up_q    <= dir_up_d;
            repeat_q    <= repeat_d;
            tri_q       <= tri_d;
            step_tick_q <= step_tick_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ftw_d       = ftw_q;
        start_d     = start_q;
        stop_d      = stop_q;
        step_d      = step_q;
        dwell_d     = dwell_q;
        dir_up_d    = dir_up_q;
        repeat_d    = repeat_q;
        tri_d       = tri_q;
        step_tick_d = 1'b0;
        done_d      = 1'b0;
        if (abort_i) begin
            state_d = StIdle;
        end else if (start_i) begin
            start_d  = start_ftw_i;
            stop_d   = stop_ftw_i;
            step_d   = step_i;
            dwell_d  = dwell_i;
            repeat_d = repeat_i;
            tri_d    = tri_i;
            ftw_d    = start_ftw_i;
            dir_up_d = (start_ftw_i <= stop_ftw_i);
            state_d  = StRamp;
        end else begin
            unique case (state_q)
                StRamp: begin
                    if (expire) begin
                        step_tick_d = 1'b1;
                        if (hit) begin
                            ftw_d   = stop_q;
                            state_d = StHold;
                        end else begin
                            ftw_d = dir_up_q ? sum[FTW_W-1:0] : diff[FTW_W-1:0];
                        end
                    end
                end
                StHold: begin
                    if (expire) begin
                        state_d = StRamp;
                        if (!repeat_q) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else if (!tri_q) begin
                            ftw_d       = start_q;
                            step_tick_d = 1'b1;
                        end else begin
                            // FTW already sits on the old stop, which becomes the new start.
                            start_d  = stop_q;
                            stop_d   = start_q;
                            dir_up_d = !dir_up_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        iftw_o      = ftw_q[FTW_W-1:FRAC_W];
        fftw_o      = ftw_q[FRAC_W-1:0];
        busy_o      = (state_q != StIdle);
        step_tick_o = step_tick_q;
        done_o      = done_q;
    end

endmodule

// File: tb/tb_nco_sweep.sv
// Randomized bench for nco_sweep against a cycle-level behavioural sweep model.
module tb_nco_sweep;

    localparam int unsigned LUTSIZE = 10;
    localparam int unsigned FRAC_W  = 8;
    localparam int unsigned DWELL_W = 16;
    localparam int unsigned FTW_W   = LUTSIZE + 1 + FRAC_W;
    localparam longint      FTW_MAX = (longint'(1) << FTW_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0, start = 1'b0, abort = 1'b0, rep = 1'b0, tri_mode = 1'b0;
    logic [FTW_W-1:0]   start_ftw = '0, stop_ftw = '0, step = '0;
    logic [DWELL_W-1:0] dwell = '0;
    logic [LUTSIZE:0]   iftw;
    logic [FRAC_W-1:0]  fftw;
    logic               busy, step_tick, done;

    int n_cmp = 0;
    int n_bad = 0;

    nco_sweep #(
        .LUTSIZE (LUTSIZE),
        .FRAC_W  (FRAC_W),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .start_i     (start),
        .abort_i     (abort),
        .start_ftw_i (start_ftw),
        .stop_ftw_i  (stop_ftw),
        .step_i      (step),
        .dwell_i     (dwell),
        .repeat_i    (rep),
        .tri_i       (tri_mode),
        .iftw_o      (iftw),
        .fftw_o      (fftw),
        .busy_o      (busy),
        .step_tick_o (step_tick),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    // Model: tuning word as a plain integer walking between two endpoints.
    longint m_ftw, m_from, m_to, m_step;
    int     m_dir, m_dwell, m_cnt;
    bit     m_busy, m_at_end, m_rep, m_tri, m_tick, m_done;

    task automatic model_reset();
        m_ftw = 0; m_from = 0; m_to = 0; m_step = 0; m_dir = 1; m_dwell = 1; m_cnt = 0;
        m_busy = 0; m_at_end = 0; m_rep = 0; m_tri = 0; m_tick = 0; m_done = 0;
    endtask

    task automatic model_clock();
        longint nxt;
        longint tmp;
        m_tick = 0;
        m_done = 0;
        if (abort) begin
            m_busy = 0;
        end else if (start) begin
            m_from = longint'(start_ftw); m_to = longint'(stop_ftw); m_step = longint'(step);
            m_dwell = (dwell == 0) ? 1 : int'(dwell);
            m_rep = rep; m_tri = tri_mode;
            m_ftw = m_from; m_dir = (m_from <= m_to) ? 1 : -1;
            m_cnt = 0; m_busy = 1; m_at_end = 0;
        end else if (m_busy && en) begin
            m_cnt++;
            if (m_cnt >= m_dwell) begin
                m_cnt = 0;
                if (!m_at_end) begin
                    nxt = m_ftw + m_dir * m_step;
                    m_tick = 1;
                    if (m_step == 0 || (m_dir > 0 && (nxt >= m_to || nxt > FTW_MAX)) ||
                        (m_dir < 0 && (nxt <= m_to || nxt < 0))) begin
                        m_ftw = m_to;
                        m_at_end = 1;
                    end else begin
                        m_ftw = nxt;
                    end
                end else if (!m_rep) begin
                    m_done = 1;
                    m_busy = 0;
                end else if (!m_tri) begin
                    m_ftw = m_from; m_tick = 1; m_at_end = 0;
                end else begin
                    tmp = m_from; m_from = m_to; m_to = tmp;
                    m_dir = -m_dir; m_at_end = 0;
                end
            end
        end
    endtask

    function automatic logic [31:0] dut_tuple();
        return {10'd0, iftw, fftw, busy, step_tick, done};
    endfunction

    function automatic logic [31:0] model_tuple();
        logic [FTW_W-1:0] f;
        f = FTW_W'(m_ftw);
        return {10'd0, f, m_busy, m_tick, m_done};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got ftw=%h busy/tick/done=%b want ftw=%h busy/tick/done=%b",
                     name, $time, act[21:3], act[2:0], exp[21:3], exp[2:0]);
        end
    endtask

    // Pins both the DUT and the model to a hand-computed expectation.
    task automatic chk_lit(input string name, input logic [FTW_W-1:0] f, input logic b,
                           input logic t, input logic d);
        logic [31:0] exp;
        exp = {10'd0, f, b, t, d};
        chk({name, "_dut"}, dut_tuple(), exp);
        chk({name, "_model"}, model_tuple(), exp);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else model_clock();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cycle", dut_tuple(), model_tuple());
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic s, input logic a);
        start = s;
        abort = a;
        cycles(1);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic cfg(input int unsigned s, input int unsigned e, input int unsigned st,
                       input int unsigned dw, input bit r, input bit t);
        start_ftw = FTW_W'(s); stop_ftw = FTW_W'(e); step = FTW_W'(st);
        dwell = DWELL_W'(dw); rep = r; tri_mode = t;
    endtask

    task automatic rand_cfg();
        longint span;
        start_ftw = FTW_W'($urandom);
        stop_ftw  = ($urandom_range(0, 3) == 0) ? start_ftw : FTW_W'($urandom);
        span = longint'(start_ftw) - longint'(stop_ftw);
        if (span < 0) span = -span;
        case ($urandom_range(0, 7))
            0:       step = '0;
            1:       step = FTW_W'($urandom);
            default: step = FTW_W'(span / longint'($urandom_range(1, 5)) +
                                   longint'($urandom_range(0, 3)));
        endcase
        dwell    = DWELL_W'($urandom_range(0, 3));
        rep      = 1'($urandom_range(0, 1));
        tri_mode = 1'($urandom_range(0, 1));
    endtask

    initial begin
        cycles(3);
        chk_lit("reset", '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        en  = 1'b1;
        cycles(2);

        // Single up-sweep, dwell 4.
        cfg('h00100, 'h00400, 'h100, 4, 0, 0);
        pulse(1'b1, 1'b0);
        chk_lit("up_load", 'h00100, 1, 0, 0);
        cycles(3); chk_lit("up_dwell", 'h00100, 1, 0, 0);
        cycles(1); chk_lit("up_200", 'h00200, 1, 1, 0);
        cycles(4); chk_lit("up_300", 'h00300, 1, 1, 0);
        cycles(4); chk_lit("up_400", 'h00400, 1, 1, 0);
        cycles(3); chk_lit("up_hold", 'h00400, 1, 0, 0);
        cycles(1); chk_lit("up_done", 'h00400, 0, 0, 1);
        cycles(1); chk_lit("up_idle", 'h00400, 0, 0, 0);

        // Down-sweep with clamp, dwell 1.
        cfg('h00500, 'h00180, 'h200, 1, 0, 0);
        pulse(1'b1, 1'b0);
        chk_lit("dn_load", 'h00500, 1, 0, 0);
        cycles(1); chk_lit("dn_300", 'h00300, 1, 1, 0);
        cycles(1); chk_lit("dn_clamp", 'h00180, 1, 1, 0);
        cycles(1); chk_lit("dn_done", 'h00180, 0, 0, 1);

        // Triangle 0 -> 0x300 -> 0 -> ...
        cfg('h00000, 'h00300, 'h100, 2, 1, 1);
        pulse(1'b1, 1'b0);
        chk_lit("tri_load", 'h00000, 1, 0, 0);
        cycles(10); chk_lit("tri_back_200", 'h00200, 1, 1, 0);
        cycles(4);  chk_lit("tri_bottom", 'h00000, 1, 1, 0);
        cycles(4);  chk_lit("tri_up_again", 'h00100, 1, 1, 0);
        cycles(40);
        pulse(1'b0, 1'b1);

        // Abort mid-ramp, then start+abort together.
        cfg('h00100, 'h00400, 'h100, 4, 0, 0);
        pulse(1'b1, 1'b0);
        cycles(4); chk_lit("ab_at_200", 'h00200, 1, 1, 0);
        pulse(1'b0, 1'b1);
        chk_lit("ab_idle", 'h00200, 0, 0, 0);
        cfg('h50000, 'h60000, 'h100, 1, 0, 0);
        pulse(1'b1, 1'b1);
        chk_lit("ab_prio", 'h00200, 0, 0, 0);

        // Huge step near the top of the range clamps without wrapping.
        cfg('h7FF00, 'h7FFFF, 'h7FFFF, 1, 0, 0);
        pulse(1'b1, 1'b0);
        cycles(1); chk_lit("top_clamp", 'h7FFFF, 1, 1, 0);
        cycles(1); chk_lit("top_done", 'h7FFFF, 0, 0, 1);

        // Asynchronous reset mid-sweep.
        cfg('h00000, 'h7FFFF, 'h1, 1, 0, 0);
        pulse(1'b1, 1'b0);
        cycles(5);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk_lit("async_rst", '0, 0, 0, 0);
        cycles(1);
        rst = 1'b0;

        // Random phase: gated enable, restarts, aborts, config noise between starts.
        for (int t = 0; t < 80; t++) begin
            rand_cfg();
            start = 1'b1;
            abort = ($urandom_range(0, 15) == 0);
            cycles(1);
            start = 1'b0;
            abort = 1'b0;
            for (int c = 0; c < int'($urandom_range(10, 60)); c++) begin
                en    = ($urandom_range(0, 3) != 0);
                abort = ($urandom_range(0, 49) == 0);
                start_ftw = FTW_W'($urandom);
                stop_ftw  = FTW_W'($urandom);
                step      = FTW_W'($urandom);
                dwell     = DWELL_W'($urandom);
                rep       = 1'($urandom);
                tri_mode  = 1'($urandom);
                cycles(1);
                abort = 1'b0;
            end
        end
        en = 1'b1;
        cycles(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nco_sweep.md
# nco_sweep

Frequency-sweep controller that sits directly upstream of the NCO and drives its integer/fractional frequency tuning word. It steps the tuning word from a start value toward a stop value at a programmable step size and dwell time, producing single, repeating-sawtooth or triangle chirps. Outputs are registered and connect directly to the NCO's `Iftw`/`Fftw` inputs.

## Interface
- `LUTSIZE`, 10: NCO LUT address MSB index; integer FTW is `LUTSIZE+1` bits.
- `FRAC_W`, 8: fractional FTW width.
- `DWELL_W`, 16: dwell counter width.
- Derived `FTW_W = LUTSIZE+1+FRAC_W` (19 by default). Full tuning word = {integer, fraction}.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  advance enable; gates the dwell counter only.
- `start`  in  1  one-cycle pulse; latches the configuration and begins a sweep.
- `abort`  in  1  one-cycle pulse; stops the sweep immediately.
- `start_ftw`  in  FTW_W  sweep start word.
- `stop_ftw`  in  FTW_W  sweep end word.
- `step`  in  FTW_W  unsigned increment magnitude per dwell.
- `dwell`  in  DWELL_W  enabled cycles per step; 0 is treated as 1.
- `repeat`  in  1  restart after reaching the endpoint.
- `tri`  in  1  with `repeat`, reverse direction at each endpoint.
- `iftw`  out  LUTSIZE+1  integer FTW to the NCO; reset 0.
- `fftw`  out  FRAC_W  fractional FTW to the NCO; reset 0.
- `busy`  out  1  high in RAMP or HOLD; reset 0.
- `step_tick`  out  1  one-cycle pulse on every FTW update after the initial load; reset 0.
- `done`  out  1  one-cycle pulse at the end of a non-repeating sweep; reset 0.

## Operation
- States: IDLE, RAMP, HOLD. Reset enters IDLE with all outputs at 0.
- IDLE + `start`:
  - Latch all configuration inputs.
  - Load FTW = `start_ftw`.
  - Set direction: up if `start_ftw <= stop_ftw`, else down.
  - Clear the dwell counter and enter RAMP.
- RAMP: the dwell counter increments on cycles with `en`=1. On reaching `max(dwell,1)` it clears and the FTW updates:
  - Up: next = FTW + step. Down: next = FTW − step. Compute in FTW_W+1 bits.
  - If next passes or equals stop, or overflows/underflows, or `step`=0: FTW = stop and go to HOLD. Otherwise FTW = next and stay in RAMP.
- HOLD: dwell once more at the stop value. On expiry:
  - `repeat`=0: pulse `done`, go to IDLE. FTW is retained.
  - `repeat`=1, `tri`=0: FTW = latched start, go to RAMP.
  - `repeat`=1, `tri`=1: swap the latched start and stop, invert direction, go to RAMP. FTW is already at the new start.
- `abort` in any state: go to IDLE next cycle. FTW is retained; no `done` pulse. `abort` has priority over `start` in the same cycle.
- `start` while busy: restart (reload config, FTW = new `start_ftw`).
- `start_ftw == stop_ftw`: the first dwell expiry goes straight to HOLD.
- Configuration inputs are ignored except on the `start` cycle.

## Timing
- `start` at cycle N: `iftw`/`fftw` = `start_ftw` and `busy`=1 at N+1.
- With `en` held high, each FTW update occurs `max(dwell,1)` cycles after the previous one. `step_tick` is asserted in the same cycle the new FTW appears.
- `en`=0 freezes the dwell count and FTW. State changes from `start`/`abort` still occur.
- `done` is asserted in the same cycle `busy` falls; `iftw`/`fftw` stay at stop.
- `rst` asynchronously clears state, counters and outputs mid-sweep.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `nco_pkg`:
  - State enum {IDLE, RAMP, HOLD}.
  - Default LUTSIZE/FRAC_W constants.
  - FTW_W derivation.
- One sub-module, `nco_dwell_timer`: enable-gated counter with a clear input and an expiry pulse; dwell=0 is treated as 1.
- The top level holds the FSM, the direction/endpoint registers and the clamped adder/subtractor.

## Test plan
- start=0x00100, stop=0x00400, step=0x100, dwell=4, repeat=0 → FTW 0x100, 0x200, 0x300, 0x400 at 4-cycle spacing; `done` 4 cycles after reaching 0x400; `busy` low after.
- start=0x00500, stop=0x00180, step=0x200, dwell=1 → 0x500, 0x300, 0x180 (clamped); then `done`.
- `repeat`=1, `tri`=1, 0x000→0x300, step 0x100, dwell=2 → 0,1,2,3,2,1,0,1… (×0x100); no `done`; continues until `abort`.
- `en` toggled 50% during a dwell=3 sweep → each step takes 3 enabled cycles; FTW never changes while `en`=0.
- `abort` mid-RAMP at FTW=0x200 → IDLE next cycle, FTW stays 0x200, no `done`. Then `start` with `abort` in the same cycle → stays IDLE.
- step=0x7FFFF near the top of range, stop=0x7FFFF → clamps to stop without wrap. `rst` asserted mid-sweep → all outputs 0 immediately.
